// File: rtl/mem_arbiter_pkg.sv
// Shared widths, state encodings and the latched transaction record
// for the instruction/data memory arbiter.
package mem_arbiter_pkg;
  localparam int WORD_SIZE       = 16;
  localparam int LATENCY_DEFAULT = 4;
  localparam int CNT_W           = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  typedef struct packed {
    owner_e               owner;
    logic                 we;
    logic [WORD_SIZE-1:0] addr;
    logic [WORD_SIZE-1:0] wdata;
  } txn_t;
endpackage

// File: rtl/mem_arbiter.sv
// Two-port (I/D) arbiter onto a single fixed-latency memory: IDLE -> ACCESS
// for LATENCY cycles -> one-cycle RESP ack, alternating grants on contention.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int LATENCY = LATENCY_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_req,
  input  logic [WORD_SIZE-1:0] i_addr,
  output logic [WORD_SIZE-1:0] i_data,
  output logic                 i_ack,
  input  logic                 d_req,
  input  logic                 d_we,
  input  logic [WORD_SIZE-1:0] d_addr,
  input  logic [WORD_SIZE-1:0] d_wdata,
  output logic [WORD_SIZE-1:0] d_rdata,
  output logic                 d_ack,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic [WORD_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0] mem_wdata,
  input  logic [WORD_SIZE-1:0] mem_rdata,
  output logic                 busy,
  output logic [15:0]          conflict_cnt
);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LATENCY - 1);

  arb_state_e       state;
  logic [CNT_W-1:0] cnt;
  owner_e           last_grant;
  txn_t             txn;
  txn_t             next_txn;
  logic             contended;

  assign contended = i_req && d_req;
  assign busy      = (state != IDLE);

  // D wins when alone, or on contention when I held the previous grant.
  always_comb begin
    next_txn = '0;
    if (d_req && (!i_req || last_grant == OWN_I)) begin
      next_txn.owner = OWN_D;
      next_txn.we    = d_we;
      next_txn.addr  = d_addr;
      next_txn.wdata = d_wdata;
    end else begin
      next_txn.owner = OWN_I;
      next_txn.addr  = i_addr;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      cnt          <= '0;
      last_grant   <= OWN_I;
      txn          <= '0;
      conflict_cnt <= '0;
      i_data       <= '0;
      d_rdata      <= '0;
      i_ack        <= 1'b0;
      d_ack        <= 1'b0;
      mem_read     <= 1'b0;
      mem_write    <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
    end else begin
      i_ack <= 1'b0;
      d_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (i_req || d_req) begin
            txn        <= next_txn;
            last_grant <= next_txn.owner;
            cnt        <= '0;
            state      <= ACCESS;
            mem_read   <= !next_txn.we;
            mem_write  <= next_txn.we;
            mem_addr   <= next_txn.addr;
            mem_wdata  <= next_txn.wdata;
            if (contended) conflict_cnt <= conflict_cnt + 16'd1;
          end
        end
        ACCESS: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST_CNT) begin
            state     <= RESP;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            // Registering the ack here makes it coincide exactly with RESP.
            if (txn.owner == OWN_D) begin
              d_ack <= 1'b1;
              if (!txn.we) d_rdata <= mem_rdata;
            end else begin
              i_ack <= 1'b1;
              if (!txn.we) i_data <= mem_rdata;
            end
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
